// File: rtl/mdu_iterative.sv
// mdu_iterative: iterative multiply/divide unit with architectural HI/LO.
// Decodes mult/multu/div/divu/mthi/mtlo from the R-type funct field.
// Multiply is radix-2 shift-add; divide is restoring, one bit per cycle.
// Optional feature macro: MDU_EARLY_TERM_EN -- mult/multu leave CALC as soon
// as the remaining multiplier bits are all zero.
module mdu_iterative #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;
    state_t r_state, w_next;

    logic [CW-1:0]      r_cnt;
    logic               r_is_div, r_neg_res, r_neg_rem, r_dbz, r_done;
    logic [2*WIDTH-1:0] r_mcand, r_acc;
    logic [WIDTH-1:0]   r_opb, r_quo, r_rem, r_hi, r_lo;

    logic               w_accept, w_is_mul, w_is_div, w_signed;
    logic               w_a_neg, w_b_neg, w_b_zero, w_last, w_ge;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_sub, w_quo_fix, w_rem_fix, w_dvd_fix;
    logic [WIDTH:0]     w_trial;
    logic [2*WIDTH-1:0] w_prod_fix;

    // Decode, operand magnitudes, divide step and sign correction
    always_comb begin
        w_accept   = start && (r_state == S_IDLE);
        w_is_mul   = (funct == F_MULT) || (funct == F_MULTU);
        w_is_div   = (funct == F_DIV)  || (funct == F_DIVU);
        w_signed   = (funct == F_MULT) || (funct == F_DIV);
        w_a_neg    = w_signed && a[WIDTH-1];
        w_b_neg    = w_signed && b[WIDTH-1];
        w_a_mag    = w_a_neg ? -a : a;
        w_b_mag    = w_b_neg ? -b : b;
        w_b_zero   = (b == '0);
        // Trial remainder is WIDTH+1 bits; the difference always fits in WIDTH
        w_trial    = {r_rem, r_quo[WIDTH-1]};
        w_ge       = (w_trial >= {1'b0, r_opb});
        w_sub      = w_trial[WIDTH-1:0] - r_opb;
        w_last     = (r_cnt == CW'(1));
`ifdef MDU_EARLY_TERM_EN
        if (!r_is_div && (r_opb[WIDTH-1:1] == '0)) begin
            w_last = 1'b1;
        end
`endif
        w_prod_fix = r_neg_res ? -r_acc : r_acc;
        w_quo_fix  = r_neg_res ? -r_quo : r_quo;
        w_rem_fix  = r_neg_rem ? -r_rem : r_rem;
        // Zero-divisor path skips CALC, so r_quo still holds |dividend|
        w_dvd_fix  = r_neg_rem ? -r_quo : r_quo;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && (w_is_mul || w_is_div)) begin
                    w_next = (w_is_div && w_b_zero) ? S_FIX : S_CALC;
                end
            end
            S_CALC:  w_next = w_last ? S_FIX : S_CALC;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy        = (r_state != S_IDLE);
        done        = r_done;
        div_by_zero = r_dbz;
        hi          = r_hi;
        lo          = r_lo;
    end

    // Datapath: operand latch, iteration engine, HI/LO write-back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_dbz     <= 1'b0;
            r_done    <= 1'b0;
            r_mcand   <= '0;
            r_acc     <= '0;
            r_opb     <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (funct == F_MTHI) begin
                            r_hi <= a;
                        end
                        if (funct == F_MTLO) begin
                            r_lo <= a;
                        end
                        if (w_is_mul || w_is_div) begin
                            r_is_div  <= w_is_div;
                            r_neg_res <= w_a_neg ^ w_b_neg;
                            r_neg_rem <= w_a_neg;
                            r_dbz     <= w_is_div && w_b_zero;
                            r_mcand   <= {{WIDTH{1'b0}}, w_a_mag};
                            r_acc     <= '0;
                            r_opb     <= w_b_mag;
                            r_quo     <= w_a_mag;
                            r_rem     <= '0;
                            r_cnt     <= CW'(WIDTH);
                        end
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_is_div) begin
                        r_rem <= w_ge ? w_sub : w_trial[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], w_ge};
                    end else begin
                        if (r_opb[0]) begin
                            r_acc <= r_acc + r_mcand;
                        end
                        r_mcand <= r_mcand << 1;
                        r_opb   <= r_opb >> 1;
                    end
                end
                S_FIX: begin
                    r_done <= 1'b1;
                    if (!r_is_div) begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end else if (r_dbz) begin
                        r_hi <= w_dvd_fix;
                        r_lo <= '1;
                    end else begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iterative.sv
// tb_mdu_iterative: randomized self-checking bench for mdu_iterative
// (WIDTH=32) against a plain-arithmetic reference model.
module tb_mdu_iterative;
    localparam int W = 32;

    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [5:0]   funct;
    logic [W-1:0] a, b;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    int n_checks = 0;
    int n_errors = 0;

    // Architectural state as the model sees it
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic         m_dbz = 1'b0;

    mdu_iterative #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .funct(funct),
        .a(a), .b(b), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int msb_idx(input logic [W-1:0] v);
        int m = 0;
        for (int i = 0; i < W; i++) if (v[i]) m = i;
        return m;
    endfunction

    // Reference: results from 64-bit arithmetic, latency counted in edges after acceptance
    task automatic model(input logic [5:0] f, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         output logic [W-1:0] eh, output logic [W-1:0] el,
                         output logic edbz, output int elat);
        longint       sa, sb;
        logic [63:0]  p;
        logic [W-1:0] babs;
        sa   = longint'($signed(ia));
        sb   = longint'($signed(ib));
        edbz = 1'b0;
        elat = W + 1;
        eh   = '0;
        el   = '0;
        babs = ib;
        case (f)
            F_MULT: begin
                p    = 64'(sa * sb);
                eh   = p[63:32];
                el   = p[31:0];
                babs = (sb < 0) ? 32'(-sb) : ib;
            end
            F_MULTU: begin
                p  = {32'b0, ia} * {32'b0, ib};
                eh = p[63:32];
                el = p[31:0];
            end
            F_DIV: begin
                if (ib == 0) begin
                    eh = ia; el = '1; edbz = 1'b1; elat = 1;
                end else begin
                    el = 32'(sa / sb);
                    eh = 32'(sa % sb);
                end
            end
            default: begin
                if (ib == 0) begin
                    eh = ia; el = '1; edbz = 1'b1; elat = 1;
                end else begin
                    el = ia / ib;
                    eh = ia % ib;
                end
            end
        endcase
`ifdef MDU_EARLY_TERM_EN
        if (f == F_MULT || f == F_MULTU) elat = msb_idx(babs) + 2;
`endif
    endtask

    task automatic run_op(input logic [5:0] f, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input bit inject);
        logic [W-1:0] eh, el;
        logic         edbz;
        int           elat, lat;
        bit           muldiv;
        muldiv = (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
        @(negedge clk);
        start = 1'b1; funct = f; a = ia; b = ib;
        @(posedge clk); #1;
        start = 1'b0; funct = 6'($urandom); a = $urandom; b = $urandom;
        if (!muldiv) begin
            if (f == F_MTHI) m_hi = ia;
            if (f == F_MTLO) m_lo = ia;
            check("idle_busy", busy, 0);
            check("idle_done", done, 0);
            check("idle_hi", hi, m_hi);
            check("idle_lo", lo, m_lo);
            check("idle_dbz", div_by_zero, m_dbz);
        end else begin
            model(f, ia, ib, eh, el, edbz, elat);
            check("start_busy", busy, 1);
            check("start_done", done, 0);
            check("start_dbz", div_by_zero, edbz);
            lat = 0;
            while (!done && lat < 200) begin
                if (inject && lat == 5) begin
                    start = 1'b1; funct = F_DIVU; a = $urandom; b = '0;
                end else begin
                    start = 1'b0;
                end
                @(posedge clk); #1;
                lat++;
            end
            start = 1'b0;
            check("done_seen", done, 1);
            check("latency", lat, elat);
            check("done_busy", busy, 0);
            check("res_hi", hi, eh);
            check("res_lo", lo, el);
            check("res_dbz", div_by_zero, edbz);
            m_hi = eh; m_lo = el; m_dbz = edbz;
        end
    endtask

    task automatic reset_mid_op();
        @(negedge clk);
        start = 1'b1; funct = F_MULT; a = $urandom; b = $urandom;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dbz", div_by_zero, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        m_hi = '0; m_lo = '0; m_dbz = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [W-1:0] rand_opnd();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 32'd1;
            2:       return '1;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [5:0] pool [8];
        pool = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO, 6'h20, 6'h10};
        rst_n = 1'b0; start = 1'b0; funct = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_dbz", div_by_zero, 0);
        check("reset_hi", hi, 0);
        check("reset_lo", lo, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(F_MULT,  32'hFFFF_FFFD, 32'd5, 0);
        run_op(F_MULTU, 32'hFFFF_FFFF, 32'd2, 0);
        run_op(F_DIV,   32'hFFFF_FFF9, 32'd2, 0);
        run_op(F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(F_DIVU,  32'h0000_1234, 32'd0, 0);
        run_op(F_MULT,  $urandom, $urandom, 0);
        run_op(F_DIV,   32'hFFFF_FF00, 32'd0, 0);
        run_op(F_MTHI,  32'h0000_00AA, $urandom, 0);
        run_op(F_MTLO,  32'h0000_0055, $urandom, 0);
        run_op(6'h20,   $urandom, $urandom, 0);
        run_op(F_MULT,  $urandom, $urandom, 1);
        run_op(F_MULTU, 32'h0000_0007, 32'd0, 0);
        reset_mid_op();
        run_op(F_DIVU,  $urandom, 32'd3, 0);

        for (int i = 0; i < 40; i++) begin
            run_op(pool[$urandom_range(0, 7)], rand_opnd(), rand_opnd(), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
